// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 sizes, FSM states, byte-strobe constants.
// Also provides the size decode and alignment check used by the top and by the lane aligner.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // BU/HU only exist for loads; every other unknown code falls back to word.
    function automatic size_t acc_size(input logic [2:0] f3, input logic is_load);
        size_t sz;
        if (f3 == F3_B || (is_load && f3 == F3_BU)) begin
            sz = SZ_B;
        end else if (f3 == F3_H || (is_load && f3 == F3_HU)) begin
            sz = SZ_H;
        end else begin
            sz = SZ_W;
        end
        return sz;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replicate/strobe and load select/extend.
// Zero latency, no state, no backpressure.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_val_o
);

    size_t       sz;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        sz     = acc_size(funct3_i, is_load_i);
        byte_v = 8'(rdata_i >> {addr_lo_i, 3'b000});
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        // funct3[2] marks the unsigned load variants.
        sext   = ~funct3_i[2];

        wdata_o    = store_data_i;
        wstrb_o    = WSTRB_W;
        load_val_o = rdata_i;
        case (sz)
            SZ_B: begin
                wdata_o    = {4{store_data_i[7:0]}};
                wstrb_o    = WSTRB_B << addr_lo_i;
                load_val_o = {{24{sext & byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                wdata_o    = {2{store_data_i[15:0]}};
                wstrb_o    = WSTRB_H << addr_lo_i;
                load_val_o = {{16{sext & half_v[15]}}, half_v};
            end
            default: begin
                wdata_o    = store_data_i;
                wstrb_o    = WSTRB_W;
                load_val_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: one req/ack data-memory transaction per load/store, MEM/WB outputs registered (latency 1).
// Stalls upstream from the issuing cycle until the ack or timeout cycle; misaligned ops retire with no request.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [31:0]   alu_result,
    input  logic [31:0]   store_data,
    input  logic [2:0]    funct3,
    input  logic          MEM_ren_in,
    input  logic          MEM_wen_in,
    input  logic [4:0]    Rd_in,
    input  logic          WB_sel_in,
    input  logic          Reg_WB_in,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-3:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          wb_valid,
    output logic [31:0]   alu_out,
    output logic [31:0]   load_data,
    output logic [4:0]    Rd_out,
    output logic          WB_sel_out,
    output logic          Reg_WB_out,
    output logic          misalign_err,
    output logic          bus_err
);

    localparam int          CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          we_q, we_d;
    logic [4:0]    rd_q, rd_d;
    logic          wbsel_q, wbsel_d;
    logic          regwb_q, regwb_d;

    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   alu_out_q, alu_out_d;
    logic [31:0]   load_data_q, load_data_d;
    logic [4:0]    rd_out_q, rd_out_d;
    logic          wbsel_out_q, wbsel_out_d;
    logic          regwb_out_q, regwb_out_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;

    logic          stall_c;
    logic          mem_op;
    logic          in_bad;
    logic [31:0]   lane_wdata;
    logic [3:0]    lane_wstrb;
    logic [31:0]   lane_load;

    mem_lane_align u_lane (
        .funct3_i     (f3_q),
        .is_load_i    (~we_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (dmem_rdata),
        .wdata_o      (lane_wdata),
        .wstrb_o      (lane_wstrb),
        .load_val_o   (lane_load)
    );

    assign mem_op = ex_valid & (MEM_ren_in | MEM_wen_in);
    assign in_bad = misaligned(acc_size(funct3, ~MEM_wen_in), alu_result[1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        f3_d        = f3_q;
        we_d        = we_q;
        rd_d        = rd_q;
        wbsel_d     = wbsel_q;
        regwb_d     = regwb_q;
        wb_valid_d  = 1'b0;
        alu_out_d   = alu_out_q;
        load_data_d = load_data_q;
        rd_out_d    = rd_out_q;
        wbsel_out_d = wbsel_out_q;
        regwb_out_d = regwb_out_q;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op && !in_bad) begin
                    stall_c = 1'b1;
                    addr_d  = alu_result;
                    sdata_d = store_data;
                    f3_d    = funct3;
                    we_d    = MEM_wen_in;
                    rd_d    = Rd_in;
                    wbsel_d = WB_sel_in;
                    regwb_d = Reg_WB_in;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    // Non-mem pass-through, or a misaligned op retiring without a bus access.
                    wb_valid_d  = ex_valid;
                    alu_out_d   = alu_result;
                    load_data_d = 32'h0;
                    rd_out_d    = Rd_in;
                    wbsel_out_d = WB_sel_in;
                    regwb_out_d = Reg_WB_in & ~mem_op;
                    mis_d       = mem_op;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    wb_valid_d  = 1'b1;
                    alu_out_d   = addr_q;
                    load_data_d = we_q ? 32'h0 : lane_load;
                    rd_out_d    = rd_q;
                    wbsel_out_d = wbsel_q;
                    regwb_out_d = regwb_q;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_valid_d  = 1'b1;
                    alu_out_d   = addr_q;
                    load_data_d = 32'h0;
                    rd_out_d    = rd_q;
                    wbsel_out_d = wbsel_q;
                    regwb_out_d = 1'b0;
                    berr_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            wbsel_q     <= 1'b0;
            regwb_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            alu_out_q   <= '0;
            load_data_q <= '0;
            rd_out_q    <= '0;
            wbsel_out_q <= 1'b0;
            regwb_out_q <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            wbsel_q     <= wbsel_d;
            regwb_q     <= regwb_d;
            wb_valid_q  <= wb_valid_d;
            alu_out_q   <= alu_out_d;
            load_data_q <= load_data_d;
            rd_out_q    <= rd_out_d;
            wbsel_out_q <= wbsel_out_d;
            regwb_out_q <= regwb_out_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
        end
    end

    assign stall      = reset & stall_c;
    assign dmem_req   = (state_q == WAIT);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? addr_q[AW-1:2] : '0;
    assign dmem_wdata = (dmem_req && we_q) ? lane_wdata : 32'h0;
    assign dmem_wstrb = dmem_req ? (we_q ? lane_wstrb : WSTRB_W) : 4'h0;

    assign wb_valid     = wb_valid_q;
    assign alu_out      = alu_out_q;
    assign load_data    = load_data_q;
    assign Rd_out       = rd_out_q;
    assign WB_sel_out   = wbsel_out_q;
    assign Reg_WB_out   = regwb_out_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, lanes/extension, misalign, timeout, reset in WAIT.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        MEM_ren_in;
    logic        MEM_wen_in;
    logic [4:0]  Rd_in;
    logic        WB_sel_in;
    logic        Reg_WB_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] alu_out;
    logic [31:0] load_data;
    logic [4:0]  Rd_out;
    logic        WB_sel_out;
    logic        Reg_WB_out;
    logic        misalign_err;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.TIMEOUT(16), .AW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .funct3       (funct3),
        .MEM_ren_in   (MEM_ren_in),
        .MEM_wen_in   (MEM_wen_in),
        .Rd_in        (Rd_in),
        .WB_sel_in    (WB_sel_in),
        .Reg_WB_in    (Reg_WB_in),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .alu_out      (alu_out),
        .load_data    (load_data),
        .Rd_out       (Rd_out),
        .WB_sel_out   (WB_sel_out),
        .Reg_WB_out   (Reg_WB_out),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        MEM_ren_in = 1'b0;
        MEM_wen_in = 1'b0;
        dmem_ack   = 1'b0;
    endtask

    // One aligned mem op acked in its first WAIT cycle.
    task automatic do_mem(input string tag, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [29:0] exp_addr,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_ld);
        ex_valid   = 1'b1;
        MEM_ren_in = ~wen;
        MEM_wen_in = wen;
        funct3     = f3;
        alu_result = addr;
        store_data = sdata;
        Rd_in      = 5'd9;
        Reg_WB_in  = ~wen;
        #1;
        check({tag, "_stall_issue"}, stall, 1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1;
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, wen);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_wstrb"}, dmem_wstrb, exp_wstrb);
        if (wen) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        check({tag, "_stall_ack"}, stall, 0);
        tick();
        idle_inputs();
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_load_data"}, load_data, exp_ld);
        check({tag, "_alu_out"}, alu_out, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int req_cycles;

        reset      = 1'b0;
        idle_inputs();
        alu_result = '0;
        store_data = '0;
        funct3     = '0;
        Rd_in      = '0;
        WB_sel_in  = 1'b0;
        Reg_WB_in  = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_reg_wb", Reg_WB_out, 0);
        reset = 1'b1;
        tick();

        // ALU pass-through
        ex_valid   = 1'b1;
        alu_result = 32'h10;
        Rd_in      = 5'd5;
        WB_sel_in  = 1'b0;
        Reg_WB_in  = 1'b1;
        #1;
        check("alu_stall", stall, 0);
        tick();
        idle_inputs();
        check("alu_wb_valid", wb_valid, 1);
        check("alu_out", alu_out, 32'h10);
        check("alu_rd", Rd_out, 5);
        check("alu_reg_wb", Reg_WB_out, 1);
        check("alu_load_data", load_data, 0);
        tick();
        check("alu_bubble", wb_valid, 0);

        // LB 0x103, ack after 3 WAIT cycles
        ex_valid   = 1'b1;
        MEM_ren_in = 1'b1;
        funct3     = 3'b000;
        alu_result = 32'h103;
        Rd_in      = 5'd7;
        WB_sel_in  = 1'b1;
        Reg_WB_in  = 1'b1;
        stalls     = 0;
        #1;
        if (stall) stalls++;
        check("lb_req_idle", dmem_req, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lb_req_wait", dmem_req, 1);
            check("lb_no_retire", wb_valid, 0);
            if (stall) stalls++;
            tick();
        end
        check("lb_addr", dmem_addr, 30'h40);
        check("lb_wstrb", dmem_wstrb, 4'hF);
        check("lb_we", dmem_we, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF00;
        #1;
        if (stall) stalls++;
        check("lb_stall_ack", stall, 0);
        tick();
        idle_inputs();
        check("lb_wb_valid", wb_valid, 1);
        check("lb_load_data", load_data, 32'hFFFF_FF80);
        check("lb_rd", Rd_out, 7);
        check("lb_reg_wb", Reg_WB_out, 1);
        check("lb_wb_sel", WB_sel_out, 1);
        check("lb_alu_out", alu_out, 32'h103);
        check("lb_stall_cycles", stalls, 4);
        check("lb_req_after", dmem_req, 0);

        do_mem("sh",  1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0,         30'h80, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_mem("sb",  1'b1, 3'b000, 32'h301, 32'h0000_00AA, 32'h0,         30'hC0, 4'b0010, 32'hAAAA_AAAA, 32'h0);
        do_mem("lh",  1'b0, 3'b001, 32'h106, 32'h0,         32'h8001_7FFF, 30'h41, 4'hF,    32'h0,         32'hFFFF_8001);
        do_mem("lhu", 1'b0, 3'b101, 32'h106, 32'h0,         32'h8001_7FFF, 30'h41, 4'hF,    32'h0,         32'h0000_8001);
        do_mem("lbu", 1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_9A00, 32'h40, 4'hF,    32'h0,         32'h0000_009A);
        do_mem("lw",  1'b0, 3'b010, 32'h104, 32'h0,         32'hDEAD_BEEF, 30'h41, 4'hF,    32'h0,         32'hDEAD_BEEF);

        // Misaligned LW 0x105
        ex_valid   = 1'b1;
        MEM_ren_in = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h105;
        Reg_WB_in  = 1'b1;
        #1;
        check("mis_stall", stall, 0);
        tick();
        idle_inputs();
        check("mis_req", dmem_req, 0);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_err", misalign_err, 1);
        check("mis_reg_wb", Reg_WB_out, 0);
        tick();
        check("mis_pulse_end", misalign_err, 0);

        // LW with no ack: timeout
        ex_valid   = 1'b1;
        MEM_ren_in = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h200;
        Reg_WB_in  = 1'b1;
        #1;
        check("to_stall_issue", stall, 1);
        tick();
        idle_inputs();
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            if (req_cycles == 1) check("to_stall_wait", stall, 1);
            if (req_cycles == 16) check("to_stall_last", stall, 0);
            tick();
        end
        check("to_req_cycles", req_cycles, 16);
        check("to_bus_err", bus_err, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_reg_wb", Reg_WB_out, 0);
        check("to_stall_idle", stall, 0);
        tick();
        check("to_pulse_end", bus_err, 0);

        // Reset asserted during WAIT, then a late ack
        ex_valid   = 1'b1;
        MEM_ren_in = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h300;
        tick();
        idle_inputs();
        check("rw_req_wait", dmem_req, 1);
        reset = 1'b0;
        tick();
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        #1;
        check("rw_req_dropped", dmem_req, 0);
        check("rw_wb_valid", wb_valid, 0);
        tick();
        dmem_ack = 1'b0;
        check("rw_ack_ignored", wb_valid, 0);
        check("rw_req_idle", dmem_req, 0);
        check("rw_load_data", load_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
